// File: rtl/pll_init_multi.sv
// Multi-channel PLL bring-up sequencer.
// Each channel pulses its PLL reset, waits for a synchronized lock, filters it,
// and retries with stronger charge-pump / loop-filter settings on timeout until
// the attempt budget is spent. A lock loss restarts the same attempt.
module pll_init_multi #(
  parameter int         NUM_PLL         = 2,
  parameter int         CLK_PERIOD      = 20,
  parameter int         RST_NS          = 1000,
  parameter int         LOCK_TIMEOUT_NS = 200000,
  parameter int         FILT_CYC        = 64,
  parameter int         MAX_RETRY       = 4,
  parameter logic [5:0] ICP_BASE        = 6'd16,
  parameter logic [5:0] ICP_STEP        = 6'd8,
  parameter logic [2:0] LPF_BASE        = 3'd2
) (
  input  logic                   init_clk,
  input  logic                   reset,
  input  logic [NUM_PLL-1:0]     i_rst,
  input  logic [NUM_PLL-1:0]     pll_lock,
  output logic [NUM_PLL-1:0]     pll_rst,
  output logic [6*NUM_PLL-1:0]   icpsel,
  output logic [3*NUM_PLL-1:0]   lpfres,
  output logic [NUM_PLL-1:0]     o_lock,
  output logic                   all_lock,
  output logic [NUM_PLL-1:0]     fail,
  output logic [NUM_PLL-1:0]     lol
);

  localparam int RST_CYC = (RST_NS + CLK_PERIOD - 1) / CLK_PERIOD;
  localparam int TO_CYC  = (LOCK_TIMEOUT_NS + CLK_PERIOD - 1) / CLK_PERIOD;
  localparam int CNT_MAX = (RST_CYC > TO_CYC) ? RST_CYC : TO_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = $clog2(FILT_CYC + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
  localparam logic [FLT_W-1:0] FILT_LAST = FLT_W'(FILT_CYC - 1);
  localparam logic [2:0]       K_LAST    = 3'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_FILT   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  // Charge-pump setting for attempt k, saturated at the 6-bit maximum.
  function automatic logic [5:0] icp_for_k(input logic [2:0] k);
    logic [9:0] sum;
    sum = {4'd0, ICP_BASE} + ({7'd0, k} * {4'd0, ICP_STEP});
    return (sum > 10'd63) ? 6'd63 : sum[5:0];
  endfunction

  // Loop-filter resistor setting for attempt k, saturated at the 3-bit maximum.
  function automatic logic [2:0] lpf_for_k(input logic [2:0] k);
    logic [3:0] sum;
    sum = {1'b0, LPF_BASE} + {1'b0, k};
    return (sum > 4'd7) ? 3'd7 : sum[2:0];
  endfunction

  logic [NUM_PLL-1:0] lock_meta_q, lock_meta_d;
  logic [NUM_PLL-1:0] lock_s_q, lock_s_d;
  logic               all_lock_q, all_lock_d;

  // Two-flop synchronizer inputs and the aggregate lock.
  always_comb begin
    lock_meta_d = pll_lock;
    lock_s_d    = lock_meta_q;
    all_lock_d  = &o_lock;
  end

  // Synchronizer and aggregate-lock registers.
  always_ff @(posedge init_clk or posedge reset) begin
    if (reset) begin
      lock_meta_q <= '0;
      lock_s_q    <= '0;
      all_lock_q  <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      all_lock_q  <= all_lock_d;
    end
  end

  assign all_lock = all_lock_q;

  for (genvar n = 0; n < NUM_PLL; n++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FLT_W-1:0] filt_q, filt_d;
    logic [2:0]       k_q, k_d;
    logic [5:0]       icp_q, icp_d;
    logic [2:0]       lpf_q, lpf_d;
    logic             o_lock_q, o_lock_d;
    logic             lol_q, lol_d;
    logic             timeout;
    logic             pll_rst_c, fail_c;

    // State, counters, attempt index and registered outputs.
    always_ff @(posedge init_clk or posedge reset) begin
      if (reset) begin
        state_q  <= ST_RST;
        cnt_q    <= '0;
        filt_q   <= '0;
        k_q      <= '0;
        icp_q    <= ICP_BASE;
        lpf_q    <= LPF_BASE;
        o_lock_q <= 1'b0;
        lol_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        filt_q   <= filt_d;
        k_q      <= k_d;
        icp_q    <= icp_d;
        lpf_q    <= lpf_d;
        o_lock_q <= o_lock_d;
        lol_q    <= lol_d;
      end
    end

    // Next-state logic; the restart request overrides everything else.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      filt_d   = filt_q;
      k_d      = k_q;
      o_lock_d = 1'b0;
      lol_d    = 1'b0;
      timeout  = 1'b0;
      if (i_rst[n]) begin
        // Counter held at zero so the pulse is timed from release.
        state_d = ST_RST;
        cnt_d   = '0;
        filt_d  = '0;
        k_d     = '0;
      end else begin
        unique case (state_q)
          ST_RST: begin
            if (cnt_q == RST_LAST) begin
              state_d = ST_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          ST_WAIT: begin
            if (lock_s_q[n]) begin
              state_d = ST_FILT;
              filt_d  = '0;
              cnt_d   = cnt_q + CNT_W'(1);
            end else if (cnt_q >= TO_LAST) begin
              timeout = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          ST_FILT: begin
            // The attempt timer keeps running through filtering and dropouts.
            if (lock_s_q[n] && (filt_q == FILT_LAST)) begin
              state_d = ST_LOCKED;
            end else if (cnt_q >= TO_LAST) begin
              timeout = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              if (lock_s_q[n]) begin
                filt_d = filt_q + FLT_W'(1);
              end else begin
                state_d = ST_WAIT;
              end
            end
          end
          ST_LOCKED: begin
            if (!lock_s_q[n]) begin
              // Lock lost: redo the same attempt.
              state_d = ST_RST;
              cnt_d   = '0;
              lol_d   = 1'b1;
            end else begin
              o_lock_d = 1'b1;
            end
          end
          ST_FAIL: begin
            state_d = ST_FAIL;
          end
          default: begin
            state_d = ST_RST;
            cnt_d   = '0;
          end
        endcase
        if (timeout) begin
          if (k_q == K_LAST) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_RST;
            cnt_d   = '0;
            k_d     = k_q + 3'd1;
          end
        end
      end
      // Settings track k only while in reset, so they are frozen for the attempt.
      icp_d = (state_d == ST_RST) ? icp_for_k(k_d) : icp_q;
      lpf_d = (state_d == ST_RST) ? lpf_for_k(k_d) : lpf_q;
    end

    // State-decoded outputs.
    always_comb begin
      pll_rst_c = (state_q == ST_RST);
      fail_c    = (state_q == ST_FAIL);
    end

    assign pll_rst[n]       = pll_rst_c;
    assign fail[n]          = fail_c;
    assign o_lock[n]        = o_lock_q;
    assign lol[n]           = lol_q;
    assign icpsel[6*n +: 6] = icp_q;
    assign lpfres[3*n +: 3] = lpf_q;
  end

endmodule

// File: tb/tb_pll_init_multi.sv
// Directed bench for pll_init_multi with NUM_PLL=2, 10 ns clock, 4-cycle
// reset pulse, 16-cycle lock timeout, 3-cycle filter and 3 attempts.
module tb_pll_init_multi;

  logic        init_clk = 1'b0;
  logic        reset;
  logic [1:0]  i_rst;
  logic [1:0]  pll_lock;
  logic [1:0]  pll_rst;
  logic [11:0] icpsel;
  logic [5:0]  lpfres;
  logic [1:0]  o_lock;
  logic        all_lock;
  logic [1:0]  fail;
  logic [1:0]  lol;

  int n_err = 0;
  int n_chk = 0;

  pll_init_multi #(
    .NUM_PLL(2), .CLK_PERIOD(10), .RST_NS(40), .LOCK_TIMEOUT_NS(160),
    .FILT_CYC(3), .MAX_RETRY(3), .ICP_BASE(6'd16), .ICP_STEP(6'd8), .LPF_BASE(3'd2)
  ) dut (
    .init_clk(init_clk), .reset(reset), .i_rst(i_rst), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .icpsel(icpsel), .lpfres(lpfres), .o_lock(o_lock),
    .all_lock(all_lock), .fail(fail), .lol(lol)
  );

  always #5 init_clk = ~init_clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge init_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    i_rst    = 2'b00;
    pll_lock = 2'b11;

    // Held in reset
    step(3);
    chk("rst_pll_rst",  32'(pll_rst),  32'(2'b11));
    chk("rst_icpsel",   32'(icpsel),   32'({6'd16, 6'd16}));
    chk("rst_lpfres",   32'(lpfres),   32'({3'd2, 3'd2}));
    chk("rst_o_lock",   32'(o_lock),   0);
    chk("rst_all_lock", 32'(all_lock), 0);
    chk("rst_fail",     32'(fail),     0);
    chk("rst_lol",      32'(lol),      0);

    // Both channels lock straight away
    reset = 1'b0;
    step(3);
    chk("up_rst_e3",    32'(pll_rst),  32'(2'b11));
    step(1);
    chk("up_rst_e4",    32'(pll_rst),  0);
    step(4);
    chk("up_olock_e8",  32'(o_lock),   0);
    step(1);
    chk("up_olock_e9",  32'(o_lock),   32'(2'b11));
    chk("up_all_e9",    32'(all_lock), 0);
    step(1);
    chk("up_all_e10",   32'(all_lock), 1);

    // Channel 1 one-cycle lock glitch
    step(2);
    pll_lock = 2'b01;
    step(1);
    pll_lock = 2'b11;
    step(1);
    chk("gl_lol_pre",   32'(lol),      0);
    chk("gl_olock_pre", 32'(o_lock),   32'(2'b11));
    step(1);
    chk("gl_lol",       32'(lol),      32'(2'b10));
    chk("gl_olock",     32'(o_lock),   32'(2'b01));
    chk("gl_pll_rst",   32'(pll_rst),  32'(2'b10));
    chk("gl_icp1",      32'(icpsel[11:6]), 16);
    step(1);
    chk("gl_lol_end",   32'(lol),      0);
    chk("gl_all_low",   32'(all_lock), 0);
    step(2);
    chk("gl_rst_hold",  32'(pll_rst),  32'(2'b10));
    step(1);
    chk("gl_rst_done",  32'(pll_rst),  0);
    step(5);
    chk("gl_relock",    32'(o_lock),   32'(2'b11));
    step(1);
    chk("gl_all_back",  32'(all_lock), 1);

    // Channel 0 restarted with no lock: three attempts then fail
    pll_lock = 2'b10;
    i_rst    = 2'b01;
    step(1);
    chk("nl_pll_rst",   32'(pll_rst),  32'(2'b01));
    chk("nl_olock",     32'(o_lock),   32'(2'b10));
    chk("nl_lol",       32'(lol),      0);
    chk("nl_icp0_a0",   32'(icpsel[5:0]), 16);
    chk("nl_lpf0_a0",   32'(lpfres[2:0]), 2);
    i_rst = 2'b00;
    step(4);
    chk("nl_rst0_off",  32'(pll_rst),  0);
    step(15);
    chk("nl_wait_a0",   32'(pll_rst),  0);
    chk("nl_icp0_keep", 32'(icpsel[5:0]), 16);
    step(1);
    chk("nl_rst_a1",    32'(pll_rst),  32'(2'b01));
    chk("nl_icp0_a1",   32'(icpsel[5:0]), 24);
    chk("nl_lpf0_a1",   32'(lpfres[2:0]), 3);
    step(3);
    chk("nl_rst_a1_h",  32'(pll_rst),  32'(2'b01));
    step(1);
    chk("nl_rst_a1_l",  32'(pll_rst),  0);
    step(16);
    chk("nl_icp0_a2",   32'(icpsel[5:0]), 32);
    chk("nl_lpf0_a2",   32'(lpfres[2:0]), 4);
    chk("nl_rst_a2",    32'(pll_rst),  32'(2'b01));
    step(4);
    chk("nl_rst_a2_l",  32'(pll_rst),  0);
    step(15);
    chk("nl_fail_pre",  32'(fail),     0);
    step(1);
    chk("nl_fail",      32'(fail),     32'(2'b01));
    chk("nl_fail_rst",  32'(pll_rst),  0);
    chk("nl_ch1_lock",  32'(o_lock),   32'(2'b10));
    chk("nl_all",       32'(all_lock), 0);
    chk("nl_icp1",      32'(icpsel[11:6]), 16);

    // Restart request out of FAIL, held for three cycles
    i_rst = 2'b01;
    step(1);
    chk("fr_fail",      32'(fail),     0);
    chk("fr_icp0",      32'(icpsel[5:0]), 16);
    chk("fr_lpf0",      32'(lpfres[2:0]), 2);
    chk("fr_pll_rst",   32'(pll_rst),  32'(2'b01));
    step(2);
    chk("fr_hold",      32'(pll_rst),  32'(2'b01));
    i_rst = 2'b00;
    step(3);
    chk("fr_pulse_h",   32'(pll_rst),  32'(2'b01));
    step(1);
    chk("fr_pulse_l",   32'(pll_rst),  0);

    // Short lock during FILT must not restart the attempt timer
    step(2);
    pll_lock = 2'b11;
    step(2);
    pll_lock = 2'b10;
    step(4);
    chk("fl_no_lock",   32'(o_lock),   32'(2'b10));
    step(7);
    chk("fl_pre_to",    32'(pll_rst),  0);
    chk("fl_icp_pre",   32'(icpsel[5:0]), 16);
    step(1);
    chk("fl_to_rst",    32'(pll_rst),  32'(2'b01));
    chk("fl_to_icp",    32'(icpsel[5:0]), 24);

    // Restart request coinciding with a timeout
    step(19);
    chk("ct_icp_pre",   32'(icpsel[5:0]), 24);
    i_rst = 2'b01;
    step(1);
    chk("ct_icp0",      32'(icpsel[5:0]), 16);
    chk("ct_lpf0",      32'(lpfres[2:0]), 2);
    chk("ct_pll_rst",   32'(pll_rst),  32'(2'b01));
    chk("ct_fail",      32'(fail),     0);
    i_rst = 2'b00;
    step(3);
    chk("ct_pulse_h",   32'(pll_rst),  32'(2'b01));
    step(1);
    chk("ct_pulse_l",   32'(pll_rst),  0);
    step(16);
    chk("ct_next_icp",  32'(icpsel[5:0]), 24);
    chk("ct_next_rst",  32'(pll_rst),  32'(2'b01));

    // Both locked, then asynchronous reset mid-cycle
    pll_lock = 2'b11;
    step(10);
    chk("ar_olock",     32'(o_lock),   32'(2'b11));
    chk("ar_all",       32'(all_lock), 1);
    chk("ar_icp0_pre",  32'(icpsel[5:0]), 24);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_pll_rst",   32'(pll_rst),  32'(2'b11));
    chk("ar_icpsel",    32'(icpsel),   32'({6'd16, 6'd16}));
    chk("ar_lpfres",    32'(lpfres),   32'({3'd2, 3'd2}));
    chk("ar_olock_0",   32'(o_lock),   0);
    chk("ar_all_0",     32'(all_lock), 0);
    chk("ar_fail",      32'(fail),     0);
    chk("ar_lol",       32'(lol),      0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pll_init_multi.md
PLL_INIT_MULTI -- requirements
Module: pll_init_multi

Interface
REQ-001 The block SHALL have parameter NUM_PLL, default 2, meaning the number of independent PLL channels (1..8).
REQ-002 The block SHALL have parameter CLK_PERIOD, default 20, meaning the init_clk period in ns.
REQ-003 The block SHALL have parameter RST_NS, default 1000, meaning the PLL reset pulse width in ns; RST_CYC = ceil(RST_NS/CLK_PERIOD).
REQ-004 The block SHALL have parameter LOCK_TIMEOUT_NS, default 200000, meaning the lock wait per attempt; TO_CYC = ceil(LOCK_TIMEOUT_NS/CLK_PERIOD).
REQ-005 The block SHALL have parameter FILT_CYC, default 64, meaning the consecutive-lock cycles required before lock is declared.
REQ-006 The block SHALL have parameter MAX_RETRY, default 4, meaning the calibration attempts per channel before failure (1..8).
REQ-007 The block SHALL have parameters ICP_BASE (default 6'd16), ICP_STEP (default 6'd8) and LPF_BASE (default 3'd2), meaning the calibration start values and step.
REQ-008 init_clk  in  1  free-running init clock; the only clock.
REQ-009 reset  in  1  asynchronous, active-high global reset.
REQ-010 i_rst  in  NUM_PLL  per-channel restart request, active high, synchronous.
REQ-011 pll_lock  in  NUM_PLL  raw PLL lock inputs, asynchronous to init_clk.
REQ-012 pll_rst  out  NUM_PLL  PLL reset outputs, active high.
REQ-013 icpsel  out  6*NUM_PLL  charge-pump select, channel n at bits [6n+5:6n].
REQ-014 lpfres  out  3*NUM_PLL  loop-filter resistor, channel n at bits [3n+2:3n].
REQ-015 o_lock  out  NUM_PLL  filtered per-channel lock.
REQ-016 all_lock  out  1  registered AND of all o_lock bits.
REQ-017 fail  out  NUM_PLL  channel exhausted all attempts.
REQ-018 lol  out  NUM_PLL  one-cycle loss-of-lock pulse.

Function
REQ-019 Each pll_lock bit SHALL pass a 2-flop synchronizer (lock_s); all FSM decisions SHALL use lock_s only.
REQ-020 Each channel SHALL run an independent FSM with states RST, WAIT, FILT, LOCKED, FAIL, a cycle counter, and an attempt index k (0..MAX_RETRY-1).
REQ-021 RST: pll_rst=1 for exactly RST_CYC cycles, then pll_rst=0 and WAIT with counter cleared.
REQ-022 WAIT: lock_s=1 -> FILT with filter count 0; else on counter = TO_CYC-1 -> FAIL if k=MAX_RETRY-1, else k<=k+1 and RST.
REQ-023 FILT: lock_s high FILT_CYC consecutive cycles -> LOCKED; lock_s low -> WAIT with the timeout counter continuing (not cleared); timeout expiry in FILT SHALL act as in WAIT.
REQ-024 LOCKED: o_lock=1; lock_s low -> o_lock=0 next cycle, lol pulses one cycle, RST with k unchanged.
REQ-025 FAIL: pll_rst=0, fail=1, o_lock=0; exit only via i_rst or reset.
REQ-026 icpsel SHALL equal min(ICP_BASE + k*ICP_STEP, 63) and lpfres SHALL equal min(LPF_BASE + k, 7), both registered and updated on entry to RST, stable for the whole attempt.
REQ-027 i_rst[n]=1 in any state SHALL force RST with k=0, counter cleared, o_lock/fail/lol low; RST SHALL be held while i_rst stays high and the pulse timed from its release.
REQ-028 i_rst taking precedence over lock loss and timeout in the same cycle.
REQ-029 all_lock SHALL lag o_lock changes by exactly one cycle.

Reset
REQ-030 While reset is high all channels SHALL be in RST with pll_rst all 1, k=0, icpsel=ICP_BASE, lpfres=LPF_BASE, o_lock=0, all_lock=0, fail=0, lol=0, synchronizers 0; the RST_CYC count SHALL start on the first edge after release.

Verification (NUM_PLL=2, CLK_PERIOD=10, RST_NS=40, LOCK_TIMEOUT_NS=160, FILT_CYC=3, MAX_RETRY=3, ICP_BASE=16, ICP_STEP=8, LPF_BASE=2)
REQ-031 Release reset, pll_lock=2'b11 constant -> pll_rst low after 4 cycles; o_lock=11 3+2 cycles later; all_lock one cycle after that.
REQ-032 Channel 0 lock never rises -> three 4-cycle reset pulses with icpsel0=16,24,32 and lpfres0=2,3,4; fail[0]=1 after the third 16-cycle timeout; channel 1 unaffected.
REQ-033 Channel 1 locked, pll_lock[1] glitches low one cycle -> lol[1] one pulse, o_lock[1]=0, pll_rst[1] 4-cycle pulse, icpsel1 unchanged, relock.
REQ-034 pll_lock[0] high 2 cycles then low during FILT -> no o_lock, timeout counter not reset, attempt ends on original schedule.
REQ-035 i_rst[0] asserted in FAIL and in same cycle as a timeout -> k=0, icpsel0=16, fail[0]=0, full reset pulse after release.
REQ-036 reset asserted mid-LOCKED -> all outputs to REQ-030 values asynchronously, before next init_clk edge.
